// File: rtl/bcd_seg_if.sv
// bcd_seg_if: start/value request and busy/done/overflow/digit result bundle
// ports: master drives start,value; slave drives busy,done,overflow,digit0..3
interface bcd_seg_if #(parameter int WIDTH = 14);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [7:0]       digit0;
  logic [7:0]       digit1;
  logic [7:0]       digit2;
  logic [7:0]       digit3;
  modport master (output start, value, input busy, done, overflow, digit0, digit1, digit2, digit3);
  modport slave (input start, value, output busy, done, overflow, digit0, digit1, digit2, digit3);
endinterface

// File: rtl/bcd_segment_encoder.sv
// bcd_segment_encoder: binary to four active-low 7-segment digits via sequential double-dabble
// ports: clk, rst (sync active-high), bus (slave: start,value in; busy,done,overflow,digit0..3 out)
module bcd_segment_encoder #(
  parameter int WIDTH         = 14,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  bcd_seg_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d, adj;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d, ovf_q, ovf_d, done_q, done_d;
  logic [3:0][7:0]  dig_q, dig_d, enc;
  logic             b3, b2, b1;
  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hBF;
    endcase
  endfunction
  always_comb begin
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = bcd_q[i*4 +: 4] >= 4'd5 ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
  end
  // blanking cascades from the left: a digit may only blank if everything left of it did
  always_comb begin
    b3 = BLANK_LEADING && bcd_q[15:12] == 4'd0;
    b2 = b3 && bcd_q[11:8] == 4'd0;
    b1 = b2 && bcd_q[7:4] == 4'd0;
    enc[3] = b3 ? 8'hFF : seg(bcd_q[15:12]);
    enc[2] = b2 ? 8'hFF : seg(bcd_q[11:8]);
    enc[1] = b1 ? 8'hFF : seg(bcd_q[7:4]);
    enc[0] = seg(bcd_q[3:0]);
  end
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        bin_d   = bus.value;
        bcd_d   = '0;
        cnt_d   = 4'(WIDTH - 1);
        pend_d  = 32'(bus.value) > 32'd9999;
      end
      SHIFT: begin
        // add-3 correction and shift in one step; top BCD bit falls off (only when overflowing)
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? ENCODE : SHIFT;
      end
      ENCODE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = pend_q;
        dig_d   = pend_q ? {4{8'hBF}} : enc;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
    end
  end
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digit0   = dig_q[0];
  assign bus.digit1   = dig_q[1];
  assign bus.digit2   = dig_q[2];
  assign bus.digit3   = dig_q[3];
endmodule

// File: tb/tb_bcd_segment_encoder.sv
// tb_bcd_segment_encoder: table-driven check of both blanking variants plus multi-cycle corner cases
module tb_bcd_segment_encoder;
  localparam int W = 14;
  localparam int LAT = W + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bcd_seg_if #(.WIDTH(W)) if1 ();
  bcd_seg_if #(.WIDTH(W)) if0 ();
  assign if0.start = if1.start;
  assign if0.value = if1.value;
  bcd_segment_encoder #(.WIDTH(W), .BLANK_LEADING(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_segment_encoder #(.WIDTH(W), .BLANK_LEADING(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  always #5 clk = ~clk;
  logic [31:0] d1, d0, prev1, prev0;
  logic prev_ovf;
  assign d1 = {if1.digit3, if1.digit2, if1.digit1, if1.digit0};
  assign d0 = {if0.digit3, if0.digit2, if0.digit1, if0.digit0};
  typedef struct {
    int          v;
    logic [31:0] e1;
    logic [31:0] e0;
    logic        ovf;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic conv(input int v, input logic [31:0] e1, input logic [31:0] e0, input logic ovf);
    int lat;
    logic busy_ok, hold_ok;
    if1.value = W'(v);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!if1.done && lat < 40) begin
      if (!if1.busy || !if0.busy) busy_ok = 1'b0;
      if (d1 !== prev1 || d0 !== prev0 || if1.overflow !== prev_ovf) hold_ok = 1'b0;
      tick();
      lat++;
    end
    chk($sformatf("latency v=%0d", v), 32'(lat), 32'(LAT));
    chk($sformatf("busy_during v=%0d", v), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("hold v=%0d", v), {31'd0, hold_ok}, 32'd1);
    chk($sformatf("busy_at_done v=%0d", v), {31'd0, if1.busy}, 32'd0);
    chk($sformatf("digits_bl1 v=%0d", v), d1, e1);
    chk($sformatf("digits_bl0 v=%0d", v), d0, e0);
    chk($sformatf("ovf v=%0d", v), {30'd0, if1.overflow, if0.overflow}, {30'd0, ovf, ovf});
    tick();
    chk($sformatf("done_width v=%0d", v), {31'd0, if1.done}, 32'd0);
    prev1 = e1;
    prev0 = e0;
    prev_ovf = ovf;
  endtask
  initial begin
    int ndone, first_done, de[2];
    logic [7:0] dd[2];
    logic hold_ok;
    tv[0]  = '{1234,  32'hF9A4B099, 32'hF9A4B099, 1'b0};
    tv[1]  = '{0,     32'hFFFFFFC0, 32'hC0C0C0C0, 1'b0};
    tv[2]  = '{7,     32'hFFFFFFF8, 32'hC0C0C0F8, 1'b0};
    tv[3]  = '{405,   32'hFF99C092, 32'hC099C092, 1'b0};
    tv[4]  = '{9999,  32'h90909090, 32'h90909090, 1'b0};
    tv[5]  = '{10000, 32'hBFBFBFBF, 32'hBFBFBFBF, 1'b1};
    tv[6]  = '{42,    32'hFFFF99A4, 32'hC0C099A4, 1'b0};
    tv[7]  = '{16383, 32'hBFBFBFBF, 32'hBFBFBFBF, 1'b1};
    tv[8]  = '{10,    32'hFFFFF9C0, 32'hC0C0F9C0, 1'b0};
    tv[9]  = '{100,   32'hFFF9C0C0, 32'hC0F9C0C0, 1'b0};
    tv[10] = '{8000,  32'h80C0C0C0, 32'h80C0C0C0, 1'b0};
    if1.start = 1'b0;
    if1.value = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_digits_bl1", d1, 32'hFFFFFFFF);
    chk("reset_digits_bl0", d0, 32'hFFFFFFFF);
    chk("reset_flags", {29'd0, if1.busy, if1.done, if1.overflow}, 32'd0);
    prev1 = 32'hFFFFFFFF;
    prev0 = 32'hFFFFFFFF;
    prev_ovf = 1'b0;
    for (int i = 0; i < 11; i++) conv(tv[i].v, tv[i].e1, tv[i].e0, tv[i].ovf);
    // start held 5 cycles with changing value: only the first is taken
    ndone = 0;
    first_done = -1;
    hold_ok = 1'b1;
    for (int e = 0; e < 32; e++) begin
      if1.start = e < 5;
      if1.value = W'(e + 1);
      tick();
      if (if1.done) begin
        ndone++;
        if (first_done < 0) first_done = e;
      end else if (first_done < 0 && (d1 !== prev1 || d0 !== prev0)) hold_ok = 1'b0;
    end
    chk("multi_start_ndone", 32'(ndone), 32'd1);
    chk("multi_start_edge", 32'(first_done), 32'(LAT));
    chk("multi_start_hold", {31'd0, hold_ok}, 32'd1);
    chk("multi_start_bl1", d1, 32'hFFFFFFF9);
    chk("multi_start_bl0", d0, 32'hC0C0C0F9);
    // start held continuously: back-to-back conversions of 1 then 2
    ndone = 0;
    de = '{-1, -1};
    dd = '{8'h00, 8'h00};
    if1.value = W'(1);
    for (int e = 0; e < 40; e++) begin
      if1.start = e <= LAT + 1;
      tick();
      if (e == 0) if1.value = W'(2);
      if (if1.done) begin
        if (ndone < 2) begin
          de[ndone] = e;
          dd[ndone] = if1.digit0;
        end
        ndone++;
      end
    end
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_first_edge", 32'(de[0]), 32'(LAT));
    chk("b2b_spacing", 32'(de[1] - de[0]), 32'(LAT + 1));
    chk("b2b_digit0_first", {24'd0, dd[0]}, 32'h000000F9);
    chk("b2b_digit0_second", {24'd0, dd[1]}, 32'h000000A4);
    prev1 = 32'hFFFFFFA4;
    prev0 = 32'hC0C0C0A4;
    prev_ovf = 1'b0;
    // reset during the 8th SHIFT cycle discards the conversion
    if1.value = W'(5678);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_digits_bl1", d1, 32'hFFFFFFFF);
    chk("midrst_digits_bl0", d0, 32'hFFFFFFFF);
    chk("midrst_flags", {29'd0, if1.busy, if1.done, if1.overflow}, 32'd0);
    ndone = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (if1.done || if1.busy) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    prev1 = 32'hFFFFFFFF;
    prev0 = 32'hFFFFFFFF;
    conv(42, 32'hFFFF99A4, 32'hC0C099A4, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
